// File: rtl/wactrl_pkg.sv
// Shared definitions for the multi-channel start-address controller:
// mode indices, data-source codes, controller states and the request
// priority helper.
package wactrl_pkg;

    localparam int N_MODES = 11;

    localparam logic [3:0] MODE_UP                 = 4'd0;
    localparam logic [3:0] MODE_DOWN               = 4'd1;
    localparam logic [3:0] MODE_POWERON            = 4'd2;
    localparam logic [3:0] MODE_POWEROFF           = 4'd3;
    localparam logic [3:0] MODE_SHAKE_BF_PASS      = 4'd4;
    localparam logic [3:0] MODE_SHAKE_BT_PASS      = 4'd5;
    localparam logic [3:0] MODE_PRINT              = 4'd6;
    localparam logic [3:0] MODE_FILL_ZEROS         = 4'd7;
    localparam logic [3:0] MODE_FILL_ONES          = 4'd8;
    localparam logic [3:0] MODE_SHAKE_BF_PASS_UP   = 4'd9;
    localparam logic [3:0] MODE_SHAKE_BF_PASS_DOWN = 4'd10;
    localparam logic [3:0] MODE_LAST               = MODE_SHAKE_BF_PASS_DOWN;

    localparam logic [7:0] DTYPE_NONE = 8'h00;
    localparam logic [7:0] DTYPE_ZERO = 8'h01;
    localparam logic [7:0] DTYPE_ONE  = 8'h02;
    localparam logic [7:0] DTYPE_MAIN = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_APPLY = 2'd2
    } wactrl_state_e;

    // Lowest set bit wins when several requests arrive together.
    function automatic logic [3:0] lowest_set_bit(input logic [N_MODES-1:0] req);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_MODES - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] mode_dtype(input logic [3:0] mode);
        logic [7:0] dt;
        case (mode)
            MODE_POWERON, MODE_POWEROFF: dt = DTYPE_NONE;
            MODE_FILL_ZEROS:             dt = DTYPE_ZERO;
            MODE_FILL_ONES:              dt = DTYPE_ONE;
            default:                     dt = DTYPE_MAIN;
        endcase
        return dt;
    endfunction

endpackage

// File: rtl/wactrl_chan.sv
// One channel of the start-address controller: an 11-entry address table,
// a fetch register holding the entry selected for the pending switch, and
// the output register that drives the channel's start address.
// Optional feature: WACTRL_READBACK_EN adds a combinational table read port.
module wactrl_chan
    import wactrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [3:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic              fetch_en,
    input  logic [3:0]        fetch_mode,
    input  logic              apply_en,
`ifdef WACTRL_READBACK_EN
    input  logic [3:0]        rd_mode,
    output logic [ADDR_W-1:0] rd_data,
`endif
    output logic [ADDR_W-1:0] start_addr
);

    logic [ADDR_W-1:0] tbl [N_MODES];
    logic [ADDR_W-1:0] fetch_q;

    // Table write; range checking is done by the caller before wr_en.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_MODES; i++) tbl[i] <= '0;
        end else if (wr_en) begin
            tbl[wr_mode] <= wr_data;
        end
    end

    // Capture the selected entry on entry to FETCH so a write landing in the
    // FETCH cycle cannot alter the value about to be applied.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_q <= '0;
        end else if (fetch_en) begin
            fetch_q <= tbl[fetch_mode];
        end
    end

    // Output register, loaded once per switch and held otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_addr <= '0;
        end else if (apply_en) begin
            start_addr <= fetch_q;
        end
    end

`ifdef WACTRL_READBACK_EN
    assign rd_data = (rd_mode <= MODE_LAST) ? tbl[rd_mode] : '0;
`endif

endmodule

// File: rtl/multi_ch_addr_ctrl.sv
// Multi-channel start-address controller. A request selects a mode; every
// channel's table entry for that mode is fetched and then applied to the
// outputs together with the matching data-source code.
// Optional feature: WACTRL_READBACK_EN adds rd_addr_i / rd_data_o table readback.
//
//   state | meaning
//   IDLE  | waiting for a request; entries captured on exit
//   FETCH | entries held in fetch registers; requests dropped
//   APPLY | new addresses visible, done_o high; requests dropped
module multi_ch_addr_ctrl
    import wactrl_pkg::*;
#(
    parameter int N_WAVE  = 8,
    parameter int N_LOGIC = 4,
    parameter int ADDR_W  = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [10:0]               req_i,
    input  logic                      w_wren_i,
    input  logic [7:0]                w_addr_i,
    input  logic [ADDR_W-1:0]         w_data_i,
`ifdef WACTRL_READBACK_EN
    input  logic [7:0]                rd_addr_i,
    output logic [ADDR_W-1:0]         rd_data_o,
`endif
    output logic [N_WAVE*ADDR_W-1:0]  wave_start_addr_o,
    output logic [N_LOGIC*ADDR_W-1:0] logic_start_addr_o,
    output logic [7:0]                data_type_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      drop_o
);

    localparam int N_CH = N_WAVE + N_LOGIC;
    localparam logic [4:0] N_CH_W = 5'(N_CH);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_APPLY = ST_APPLY;

    logic [1:0] state;
    logic [3:0] mode_q;
    logic       req_any;
    logic       fetch_en;
    logic       apply_en;
    logic [3:0] req_mode;
    logic [3:0] wr_ch;
    logic [3:0] wr_mode;
    logic       wr_ok;

    assign req_any  = |req_i;
    assign req_mode = lowest_set_bit(req_i);
    assign fetch_en = (state == S_IDLE) && req_any;
    assign apply_en = (state == S_FETCH);

    assign wr_ch   = w_addr_i[7:4];
    assign wr_mode = w_addr_i[3:0];
    assign wr_ok   = w_wren_i && ({1'b0, wr_ch} < N_CH_W) && (wr_mode <= MODE_LAST);

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_APPLY);
    assign drop_o = busy_o && req_any;

    // Mode-switch sequencing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (req_any) state <= S_FETCH;
                S_FETCH: state <= S_APPLY;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Latch the accepted mode and publish its data-source code with the addresses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q      <= MODE_UP;
            data_type_o <= DTYPE_NONE;
        end else begin
            if (fetch_en) mode_q <= req_mode;
            if (apply_en) data_type_o <= mode_dtype(mode_q);
        end
    end

`ifdef WACTRL_READBACK_EN
    logic [ADDR_W-1:0] rd_entry [N_CH];
    logic [ADDR_W-1:0] rd_sel;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        logic [ADDR_W-1:0] start_addr;

        wactrl_chan #(.ADDR_W(ADDR_W)) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .wr_en      (wr_ok && (wr_ch == 4'(k))),
            .wr_mode    (wr_mode),
            .wr_data    (w_data_i),
            .fetch_en   (fetch_en),
            .fetch_mode (req_mode),
            .apply_en   (apply_en),
`ifdef WACTRL_READBACK_EN
            .rd_mode    (rd_addr_i[3:0]),
            .rd_data    (rd_entry[k]),
`endif
            .start_addr (start_addr)
        );

        if (k < N_WAVE) begin : g_wave
            assign wave_start_addr_o[k*ADDR_W +: ADDR_W] = start_addr;
        end else begin : g_logic
            assign logic_start_addr_o[(k-N_WAVE)*ADDR_W +: ADDR_W] = start_addr;
        end
    end

`ifdef WACTRL_READBACK_EN
    // Channel select for readback; unknown channels read as zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (rd_addr_i[7:4] == 4'(k)) rd_sel = rd_entry[k];
        end
    end

    // Registered readback, one cycle behind rd_addr_i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_sel;
        end
    end
`endif

endmodule

// File: tb/tb_multi_ch_addr_ctrl.sv
// Directed bench for multi_ch_addr_ctrl; vector table for the mode sweep plus
// hand-written sequences for drop, fetch-cycle write, bad writes and reset abort.
// Readback checks are compiled in with WACTRL_READBACK_EN.
module tb_multi_ch_addr_ctrl #(
    parameter int N_WAVE  = 8,
    parameter int N_LOGIC = 4,
    parameter int ADDR_W  = 8
);
    localparam int N_CH = N_WAVE + N_LOGIC;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic [10:0]               req_i;
    logic                      w_wren_i;
    logic [7:0]                w_addr_i;
    logic [ADDR_W-1:0]         w_data_i;
    logic [N_WAVE*ADDR_W-1:0]  wave_start_addr_o;
    logic [N_LOGIC*ADDR_W-1:0] logic_start_addr_o;
    logic [7:0]                data_type_o;
    logic                      busy_o, done_o, drop_o;
`ifdef WACTRL_READBACK_EN
    logic [7:0]                rd_addr_i;
    logic [ADDR_W-1:0]         rd_data_o;
`endif

    multi_ch_addr_ctrl #(.N_WAVE(N_WAVE), .N_LOGIC(N_LOGIC), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .req_i              (req_i),
        .w_wren_i           (w_wren_i),
        .w_addr_i           (w_addr_i),
        .w_data_i           (w_data_i),
`ifdef WACTRL_READBACK_EN
        .rd_addr_i          (rd_addr_i),
        .rd_data_o          (rd_data_o),
`endif
        .wave_start_addr_o  (wave_start_addr_o),
        .logic_start_addr_o (logic_start_addr_o),
        .data_type_o        (data_type_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .drop_o             (drop_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] model   [16][16];
    logic [ADDR_W-1:0] cur_out [16];

    typedef struct {
        logic [10:0] req;
        int          mode;
        logic [7:0]  dt;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] chan_out(input int k);
        if (k < N_WAVE) return wave_start_addr_o[k*ADDR_W +: ADDR_W];
        return logic_start_addr_o[(k-N_WAVE)*ADDR_W +: ADDR_W];
    endfunction

    task automatic chk_outs(input string tag);
        for (int k = 0; k < N_CH; k++)
            chk($sformatf("%s ch%0d", tag, k), 32'(chan_out(k)), 32'(cur_out[k]));
    endtask

    // Starts and ends at a negedge.
    task automatic wr(input int ch, input int mode, input logic [ADDR_W-1:0] d);
        w_wren_i = 1'b1;
        w_addr_i = 8'(ch * 16 + mode);
        w_data_i = d;
        @(negedge clk);
        w_wren_i = 1'b0;
        if (ch < N_CH && mode <= 10) model[ch][mode] = d;
    endtask

    // Request at cycle T; checks FETCH (T+1), APPLY (T+2) and the idle hold (T+3).
    task automatic do_req(input logic [10:0] req, input int mode, input logic [7:0] dt, input string tag);
        chk({tag, " idle busy"}, 32'(busy_o), 32'd0);
        req_i = req;
        for (int k = 0; k < N_CH; k++) cur_out[k] = model[k][mode];
        @(negedge clk);
        req_i = '0;
        chk({tag, " fetch busy"}, 32'(busy_o), 32'd1);
        chk({tag, " fetch done"}, 32'(done_o), 32'd0);
        @(negedge clk);
        chk({tag, " apply done"}, 32'(done_o), 32'd1);
        chk({tag, " apply dtype"}, 32'(data_type_o), 32'(dt));
        chk_outs({tag, " apply"});
        @(negedge clk);
        chk({tag, " after done"}, 32'(done_o), 32'd0);
        chk({tag, " after busy"}, 32'(busy_o), 32'd0);
        chk({tag, " hold dtype"}, 32'(data_type_o), 32'(dt));
        chk_outs({tag, " hold"});
    endtask

`ifdef WACTRL_READBACK_EN
    task automatic rb_all(input string tag);
        for (int c = 0; c < 16; c++) begin
            for (int m = 0; m < 16; m++) begin
                rd_addr_i = 8'(c * 16 + m);
                @(negedge clk);
                chk($sformatf("%s rd c%0d m%0d", tag, c, m), 32'(rd_data_o),
                    (c < N_CH && m <= 10) ? 32'(model[c][m]) : 32'd0);
            end
        end
    endtask
`endif

    initial begin
        vecs[0] = '{11'h001, 0,  8'h03};
        vecs[1] = '{11'h002, 1,  8'h03};
        vecs[2] = '{11'h004, 2,  8'h00};
        vecs[3] = '{11'h008, 3,  8'h00};
        vecs[4] = '{11'h010, 4,  8'h03};
        vecs[5] = '{11'h180, 7,  8'h01};
        vecs[6] = '{11'h100, 8,  8'h02};
        vecs[7] = '{11'h400, 10, 8'h03};
        vecs[8] = '{11'h600, 9,  8'h03};
        vecs[9] = '{11'h7FF, 0,  8'h03};

        for (int c = 0; c < 16; c++) begin
            cur_out[c] = '0;
            for (int m = 0; m < 16; m++) model[c][m] = '0;
        end

        rstn = 1'b0; req_i = '0; w_wren_i = 1'b0; w_addr_i = '0; w_data_i = '0;
`ifdef WACTRL_READBACK_EN
        rd_addr_i = '0;
`endif
        @(negedge clk); @(negedge clk);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset drop", 32'(drop_o), 32'd0);
        chk("reset dtype", 32'(data_type_o), 32'd0);
        chk_outs("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Basic switch: wave ch0 and logic ch0, mode up.
        wr(0, 0, ADDR_W'(8'h12));
        wr(N_WAVE, 0, ADDR_W'(8'h34));
        do_req(11'h001, 0, 8'h03, "basic");
        chk("basic wave0", 32'(chan_out(0)), 32'h12);
        chk("basic logic0", 32'(chan_out(N_WAVE)), 32'h34);

        // Distinct entry in every channel/mode, then sweep the vector table.
        for (int c = 0; c < N_CH; c++)
            for (int m = 0; m <= 10; m++)
                wr(c, m, ADDR_W'(c * 16 + m + 1));
        for (int i = 0; i < 10; i++)
            do_req(vecs[i].req, vecs[i].mode, vecs[i].dt, $sformatf("vec%0d", i));

        // Request during FETCH and APPLY is dropped; only poweron applies.
        req_i = 11'h004;
        for (int k = 0; k < N_CH; k++) cur_out[k] = model[k][2];
        @(negedge clk);
        req_i = 11'h040;
        chk("drop fetch", 32'(drop_o), 32'd1);
        @(negedge clk);
        chk("drop apply", 32'(drop_o), 32'd1);
        chk("drop apply done", 32'(done_o), 32'd1);
        chk("drop dtype", 32'(data_type_o), 32'h00);
        chk_outs("drop apply");
        req_i = '0;
        @(negedge clk);
        chk("drop idle busy", 32'(busy_o), 32'd0);
        chk("drop idle drop", 32'(drop_o), 32'd0);
        @(negedge clk);
        chk("drop no switch", 32'(busy_o), 32'd0);
        chk("drop dtype hold", 32'(data_type_o), 32'h00);

        // Write to the active entry during FETCH applies only to the next switch.
        req_i = 11'h020;
        for (int k = 0; k < N_CH; k++) cur_out[k] = model[k][5];
        @(negedge clk);
        req_i = '0;
        w_wren_i = 1'b1; w_addr_i = 8'h05; w_data_i = ADDR_W'(8'hA5);
        @(negedge clk);
        w_wren_i = 1'b0;
        model[0][5] = ADDR_W'(8'hA5);
        chk("fetchwr done", 32'(done_o), 32'd1);
        chk_outs("fetchwr old");
        @(negedge clk);
        do_req(11'h020, 5, 8'h03, "fetchwr new");

        // Out-of-range writes leave every table untouched.
        wr(13, 0, ADDR_W'(8'h77));
        wr(0, 12, ADDR_W'(8'h77));
        wr(0, 11, ADDR_W'(8'h77));
        wr(N_WAVE, 15, ADDR_W'(8'h77));
        if (N_CH < 16) wr(N_CH, 1, ADDR_W'(8'h77));
`ifdef WACTRL_READBACK_EN
        rb_all("badwr");
`endif
        do_req(11'h001, 0, 8'h03, "badwr m0");
        do_req(11'h002, 1, 8'h03, "badwr m1");

        // Reset during FETCH aborts the switch and clears everything.
        req_i = 11'h001;
        @(negedge clk);
        req_i = '0;
        chk("rst fetch busy", 32'(busy_o), 32'd1);
        rstn = 1'b0;
        #1;
        for (int c = 0; c < 16; c++) begin
            cur_out[c] = '0;
            for (int m = 0; m < 16; m++) model[c][m] = '0;
        end
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst dtype", 32'(data_type_o), 32'd0);
        chk_outs("rst");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst no done %0d", i), 32'(done_o), 32'd0);
            chk($sformatf("rst idle %0d", i), 32'(busy_o), 32'd0);
        end
`ifdef WACTRL_READBACK_EN
        rd_addr_i = 8'h05;
        @(negedge clk);
        chk("rst table cleared", 32'(rd_data_o), 32'd0);
`endif
        wr(0, 1, ADDR_W'(8'h55));
        wr(N_WAVE, 1, ADDR_W'(8'h66));
        do_req(11'h002, 1, 8'h03, "post rst");
        chk("post rst wave0", 32'(chan_out(0)), 32'h55);
        chk("post rst logic0", 32'(chan_out(N_WAVE)), 32'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_ch_addr_ctrl.md
MULTI_CH_ADDR_CTRL -- requirements
Module: multi_ch_addr_ctrl

Interface
REQ-001 Parameter N_WAVE, default 8: number of wave channels, range 1..12.
REQ-002 Parameter N_LOGIC, default 4: number of logic channels; N_WAVE+N_LOGIC SHALL be at most 16.
REQ-003 Parameter ADDR_W, default 8: width of each start address and of the table data.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  11  one-hot-intended request vector: bit0 up, bit1 down, bit2 poweron, bit3 poweroff, bit4 shake_bf_pass, bit5 shake_bt_pass, bit6 print, bit7 fill_zeros, bit8 fill_ones, bit9 shake_bf_pass_up, bit10 shake_bf_pass_down.
REQ-007 w_wren_i  input  1  table write strobe.
REQ-008 w_addr_i  input  8  table write address: [7:4] channel (waves 0..N_WAVE-1, then logic), [3:0] mode index.
REQ-009 w_data_i  input  ADDR_W  table write data.
REQ-010 wave_start_addr_o  output  N_WAVE*ADDR_W  wave channel start addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 logic_start_addr_o  output  N_LOGIC*ADDR_W  logic channel start addresses, packed the same way.
REQ-012 data_type_o  output  8  data source code: 0x00 none, 0x01 all-zero, 0x02 all-one, 0x03 mainboard.
REQ-013 busy_o  output  1  high while a mode switch is in progress.
REQ-014 done_o  output  1  one-cycle pulse when new addresses are applied.
REQ-015 drop_o  output  1  one-cycle pulse when a request is ignored because busy_o is high.

Function
REQ-016 Each channel SHALL hold an 11-entry table of ADDR_W-bit start addresses, one entry per mode index.
REQ-017 A cycle with w_wren_i high, channel < N_WAVE+N_LOGIC and mode index <= 10 SHALL write w_data_i into that entry; any other write SHALL be ignored.
REQ-018 States: IDLE, FETCH, APPLY.
REQ-019 In IDLE, any req_i bit set SHALL latch the mode as the lowest set bit index and move to FETCH.
REQ-020 FETCH SHALL register each channel's table entry for the latched mode; the next state SHALL be APPLY.
REQ-021 APPLY SHALL load all start-address outputs and data_type_o simultaneously, pulse done_o and return to IDLE.
REQ-022 Latency: request in cycle T SHALL give updated outputs and done_o in cycle T+2.
REQ-023 busy_o SHALL be high in FETCH and APPLY.
REQ-024 A nonzero req_i in FETCH or APPLY SHALL be discarded and pulse drop_o.
REQ-025 Mode to data_type mapping: poweron/poweroff 0x00; fill_zeros 0x01; fill_ones 0x02; all others 0x03.
REQ-026 A table write to the active mode entry in the FETCH cycle SHALL NOT affect the value being applied.
REQ-027 Outputs and data_type_o SHALL hold their values between APPLY cycles.

Reset
REQ-028 While rstn is low: all table entries 0, all start-address outputs 0, data_type_o 0x00, busy_o/done_o/drop_o 0, state IDLE.
REQ-029 Reset asserted mid-switch SHALL abort the switch with no done_o.

Configuration
REQ-030 With WACTRL_READBACK_EN defined, ports rd_addr_i (input, 8) and rd_data_o (output, ADDR_W) SHALL exist.
REQ-031 With WACTRL_READBACK_EN, rd_data_o SHALL show the addressed table entry one cycle after rd_addr_i, or 0 when the address is out of range.
REQ-032 Without WACTRL_READBACK_EN, these ports and the read mux SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package wactrl_pkg SHALL hold the mode index constants, the data_type codes, the state enum and the lowest-set-bit priority function.
REQ-034 Sub-module wactrl_chan SHALL implement one channel (table, fetch register, output register); it SHALL be instantiated N_WAVE+N_LOGIC times.

Verification
REQ-035 Write ch0 mode0=0x12 and ch8 mode0=0x34 (defaults), then pulse req_i bit0 -> at T+2 wave ch0=0x12, logic ch0=0x34, data_type_o=0x03, one done_o pulse.
REQ-036 req_i=0x180 (fill_zeros and fill_ones) -> mode 7 applied, data_type_o=0x01.
REQ-037 req_i bit2 at T, then req_i bit6 at T+1 -> drop_o pulses at T+1; only poweron applied; data_type_o=0x00.
REQ-038 Write channel 13 (out of range) or mode 12 -> all tables unchanged, checked via readback with the macro defined.
REQ-039 Assert rstn low during FETCH -> all outputs 0, no done_o; the next request is served normally.
REQ-040 Rerun REQ-035 to REQ-039 with N_WAVE=2, N_LOGIC=1, ADDR_W=12, with and without WACTRL_READBACK_EN.
